// File: rtl/bu_pkg.sv
// bu_pkg: shared run-controller state encoding and default bus widths
package bu_pkg;
    typedef enum logic [1:0] {IDLE, RUN, HALT, TMO} bu_state_t;
    localparam int BU_ADDR_W = 12;
    localparam int BU_DATA_W = 16;
endpackage

// File: rtl/bu_trace_ring.sv
// bu_trace_ring: overwrite-on-full ring buffer of (address, data) store records
module bu_trace_ring #(
    parameter int DEPTH = 8,
    parameter int AW = 12,
    parameter int DW = 16,
    localparam int PW = $clog2(DEPTH),
    localparam int CW = PW + 1
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          clear,
    input  logic          push,
    input  logic          pop,
    input  logic [AW-1:0] push_addr,
    input  logic [DW-1:0] push_data,
    output logic [CW-1:0] count,
    output logic [AW-1:0] head_addr,
    output logic [DW-1:0] head_data
);
    logic [AW-1:0] mem_addr [DEPTH];
    logic [DW-1:0] mem_data [DEPTH];
    logic [PW-1:0] head, tail;
    logic full, do_pop;
    assign full = count == CW'(DEPTH);
    assign do_pop = pop && count != '0;
    // pointers and occupancy; a push into a full ring drops the oldest entry
    always_ff @(posedge clk) begin
        if (reset || clear) begin
            head  <= '0;
            tail  <= '0;
            count <= '0;
        end else begin
            if (push) tail <= tail + PW'(1);
            if (do_pop || (push && full)) head <= head + PW'(1);
            if (push && !full && !do_pop) count <= count + CW'(1);
            else if (do_pop && !push) count <= count - CW'(1);
        end
    end
    // record storage, written at the tail
    always_ff @(posedge clk) begin
        if (push) begin
            mem_addr[tail] <= push_addr;
            mem_data[tail] <= push_data;
        end
    end
    // oldest entry, forced to zero when empty
    always_comb begin
        head_addr = count != '0 ? mem_addr[head] : '0;
        head_data = count != '0 ? mem_data[head] : '0;
    end
endmodule

// File: rtl/bu_run_monitor.sv
// bu_run_monitor: start/stop run FSM with cycle budget, stall-halt detection and store trace
module bu_run_monitor #(
    parameter int ADDR_W = bu_pkg::BU_ADDR_W,
    parameter int DATA_W = bu_pkg::BU_DATA_W,
    parameter int CYC_W = 16,
    parameter int MAX_CYCLES = 2000,
    parameter int STALL_LIMIT = 8,
    parameter int TRACE_DEPTH = 8
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         start,
    input  logic [ADDR_W-1:0]            Instruction_addressbus,
    input  logic [ADDR_W-1:0]            address_bus,
    input  logic [DATA_W-1:0]            data_bus,
    input  logic                         write_mode,
    output logic [CYC_W-1:0]             cycle,
    output logic                         running,
    output logic                         halted,
    output logic                         timeout,
    output logic [$clog2(TRACE_DEPTH):0] trace_count,
    input  logic                         trace_pop,
    output logic [ADDR_W-1:0]            trace_addr,
    output logic [DATA_W-1:0]            trace_data
);
    import bu_pkg::*;
    localparam int CNT_W = $clog2(MAX_CYCLES) > CYC_W ? $clog2(MAX_CYCLES) : CYC_W;
    localparam int SW = $clog2(STALL_LIMIT);
    localparam logic [CNT_W-1:0] SAT = CNT_W'({CYC_W{1'b1}});
    bu_state_t state, state_next;
    logic [CNT_W-1:0] cnt;
    logic [SW-1:0] stall;
    logic [ADDR_W-1:0] prev_ia;
    logic rearm, stall_hit, budget_hit;
    assign rearm = start && state != RUN;
    assign stall_hit = stall == SW'(STALL_LIMIT - 1);
    assign budget_hit = cnt == CNT_W'(MAX_CYCLES - 1);
    // state register
    always_ff @(posedge clk) begin
        state <= reset ? IDLE : state_next;
    end
    // next state: halt outranks timeout when both hit together
    always_comb begin
        state_next = rearm ? RUN : state != RUN ? state : stall_hit ? HALT : budget_hit ? TMO : RUN;
    end
    // cycle counter and stall detector advance only while staying in RUN
    always_ff @(posedge clk) begin
        if (reset) begin
            cnt     <= '0;
            stall   <= '0;
            prev_ia <= '0;
        end else begin
            prev_ia <= Instruction_addressbus;
            if (rearm) begin
                cnt   <= '0;
                stall <= '0;
            end else if (state_next == RUN) begin
                cnt   <= cnt + CNT_W'(1);
                stall <= Instruction_addressbus != prev_ia ? '0 : stall + SW'(1);
            end
        end
    end
    // status decode; the visible cycle count saturates if the budget outgrows it
    always_comb begin
        running = state == RUN;
        halted  = state == HALT;
        timeout = state == TMO;
        cycle   = cnt > SAT ? '1 : cnt[CYC_W-1:0];
    end
    bu_trace_ring #(.DEPTH(TRACE_DEPTH), .AW(ADDR_W), .DW(DATA_W)) u_trace (
        .clk(clk),
        .reset(reset),
        .clear(rearm),
        .push(state == RUN && write_mode),
        .pop(trace_pop),
        .push_addr(address_bus),
        .push_data(data_bus),
        .count(trace_count),
        .head_addr(trace_addr),
        .head_data(trace_data)
    );
endmodule

// File: tb/tb_bu_run_monitor.sv
// tb_bu_run_monitor: directed self-checking bench for the run monitor
module tb_bu_run_monitor;
    logic clk = 0;
    logic reset, start, write_mode, trace_pop, running, halted, timeout, spin;
    logic [11:0] ia, address_bus, trace_addr;
    logic [15:0] data_bus, trace_data, cycle;
    logic [3:0] trace_count;
    int checks = 0;
    int errors = 0;

    bu_run_monitor #(.ADDR_W(12), .DATA_W(16), .CYC_W(16), .MAX_CYCLES(20),
                     .STALL_LIMIT(8), .TRACE_DEPTH(8)) dut (
        .clk(clk),
        .reset(reset),
        .start(start),
        .Instruction_addressbus(ia),
        .address_bus(address_bus),
        .data_bus(data_bus),
        .write_mode(write_mode),
        .cycle(cycle),
        .running(running),
        .halted(halted),
        .timeout(timeout),
        .trace_count(trace_count),
        .trace_pop(trace_pop),
        .trace_addr(trace_addr),
        .trace_data(trace_data)
    );

    always #5 clk = ~clk;

    task automatic tick();
        if (spin) ia = ia + 12'd1;
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic store(input logic [11:0] a, input logic [15:0] d);
        address_bus = a;
        data_bus = d;
        write_mode = 1;
        tick();
        write_mode = 0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        reset = 1; start = 0; ia = 0; address_bus = 0; data_bus = 0;
        write_mode = 0; trace_pop = 0; spin = 0;
        tick(); tick();
        reset = 0;
        repeat (10) tick();
        chk("rst_cycle", 32'(cycle), 0);
        chk("rst_running", 32'(running), 0);
        chk("rst_halted", 32'(halted), 0);
        chk("rst_timeout", 32'(timeout), 0);
        chk("rst_count", 32'(trace_count), 0);
        chk("rst_taddr", 32'(trace_addr), 0);
        chk("rst_tdata", 32'(trace_data), 0);

        spin = 1; start = 1; tick(); start = 0;
        for (int i = 0; i < 20; i++) begin
            chk("tmo_run_cycle", 32'(cycle), 32'(i));
            chk("tmo_running", 32'(running), 1);
            tick();
        end
        chk("tmo_flag", 32'(timeout), 1);
        chk("tmo_running_off", 32'(running), 0);
        chk("tmo_halted", 32'(halted), 0);
        chk("tmo_cycle", 32'(cycle), 19);
        repeat (3) tick();
        chk("tmo_frozen", 32'(cycle), 19);
        chk("tmo_held", 32'(timeout), 1);

        spin = 0; ia = 0; start = 1; tick(); start = 0;
        for (int i = 1; i <= 4; i++) begin
            ia = 12'(i);
            tick();
        end
        repeat (7) tick();
        chk("halt_pre_running", 32'(running), 1);
        chk("halt_pre_halted", 32'(halted), 0);
        chk("halt_pre_cycle", 32'(cycle), 11);
        tick();
        chk("halt_flag", 32'(halted), 1);
        chk("halt_running", 32'(running), 0);
        chk("halt_timeout", 32'(timeout), 0);
        chk("halt_cycle", 32'(cycle), 11);
        repeat (3) tick();
        chk("halt_frozen", 32'(cycle), 11);
        chk("halt_held", 32'(halted), 1);

        spin = 1; start = 1; tick(); start = 0;
        chk("rearm_cycle", 32'(cycle), 0);
        chk("rearm_running", 32'(running), 1);
        chk("rearm_halted", 32'(halted), 0);
        for (int i = 0; i < 10; i++) store(12'(12'hFF0 + i), 16'(16'hA000 + i));
        chk("st_count", 32'(trace_count), 8);
        chk("st_head_addr", 32'(trace_addr), 32'hFF2);
        chk("st_head_data", 32'(trace_data), 32'hA002);
        chk("st_cycle", 32'(cycle), 10);
        for (int k = 0; k < 30 && !timeout; k++) tick();
        chk("st_timeout", 32'(timeout), 1);
        write_mode = 1; address_bus = 12'hEEE; trace_pop = 1;
        for (int i = 0; i < 8; i++) begin
            chk("pop_addr", 32'(trace_addr), 32'(12'hFF2 + i));
            chk("pop_data", 32'(trace_data), 32'(16'hA002 + i));
            tick();
        end
        trace_pop = 0; write_mode = 0;
        chk("pop_empty_count", 32'(trace_count), 0);
        chk("pop_empty_addr", 32'(trace_addr), 0);
        chk("pop_empty_data", 32'(trace_data), 0);
        trace_pop = 1; tick(); trace_pop = 0;
        chk("pop_underflow", 32'(trace_count), 0);

        start = 1; tick(); start = 0;
        for (int i = 0; i < 8; i++) store(12'(12'h100 + i), 16'(16'h5000 + i));
        chk("sim_full_count", 32'(trace_count), 8);
        chk("sim_full_head", 32'(trace_addr), 32'h100);
        trace_pop = 1; store(12'h108, 16'h5008); trace_pop = 0;
        chk("sim_full_keep", 32'(trace_count), 8);
        chk("sim_full_addr", 32'(trace_addr), 32'h101);
        chk("sim_full_data", 32'(trace_data), 32'h5001);
        trace_pop = 1; repeat (5) tick(); trace_pop = 0;
        chk("sim_pop5_count", 32'(trace_count), 3);
        chk("sim_pop5_addr", 32'(trace_addr), 32'h106);
        trace_pop = 1; store(12'h109, 16'h5009); trace_pop = 0;
        chk("sim3_count", 32'(trace_count), 3);
        chk("sim3_addr", 32'(trace_addr), 32'h107);
        for (int i = 0; i < 3; i++) begin
            chk("sim3_order_addr", 32'(trace_addr), 32'(12'h107 + i));
            chk("sim3_order_data", 32'(trace_data), 32'(16'h5007 + i));
            trace_pop = 1; tick(); trace_pop = 0;
        end
        chk("sim3_empty", 32'(trace_count), 0);

        reset = 1; tick(); reset = 0;
        start = 1; tick(); start = 0;
        for (int i = 0; i < 3; i++) store(12'(12'h200 + i), 16'(16'h7000 + i));
        chk("ign_pre_cycle", 32'(cycle), 3);
        chk("ign_pre_count", 32'(trace_count), 3);
        start = 1; store(12'h203, 16'h7003); start = 0;
        chk("ign_cycle", 32'(cycle), 4);
        chk("ign_running", 32'(running), 1);
        chk("ign_count", 32'(trace_count), 4);
        chk("ign_head", 32'(trace_addr), 32'h200);
        reset = 1; start = 1; store(12'h204, 16'h7004); reset = 0; start = 0;
        chk("mid_rst_running", 32'(running), 0);
        chk("mid_rst_cycle", 32'(cycle), 0);
        chk("mid_rst_count", 32'(trace_count), 0);
        chk("mid_rst_addr", 32'(trace_addr), 0);
        chk("mid_rst_flags", 32'({halted, timeout}), 0);
        tick();
        chk("mid_rst_idle", 32'(running), 0);

        spin = 1; start = 1; tick(); start = 0;
        repeat (12) tick();
        spin = 0;
        repeat (7) tick();
        chk("both_pre_cycle", 32'(cycle), 19);
        chk("both_pre_running", 32'(running), 1);
        tick();
        chk("both_halted", 32'(halted), 1);
        chk("both_timeout", 32'(timeout), 0);
        chk("both_cycle", 32'(cycle), 19);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
